// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: response-owner tags and latency limits.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_IF   = 2'b01,
    TAG_MEM  = 2'b10
  } tag_e;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;

  // A kill squashes fetch ownership only; memory-stage reads always complete.
  function automatic tag_e kill_tag(input tag_e t, input logic kill);
    return (kill && (t == TAG_IF)) ? TAG_NONE : t;
  endfunction

endpackage

// File: rtl/lat_tag_pipe.sv
// Fixed-latency owner-tag pipeline that follows each issued read to the RAM output.
module lat_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_e i_tag,
  input  logic i_kill,
  output tag_e o_head
);

  tag_e r_stage [MEM_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_LAT; i++) r_stage[i] <= TAG_NONE;
    end else begin
      r_stage[0] <= kill_tag(i_tag, i_kill);
      for (int i = 1; i < MEM_LAT; i++) r_stage[i] <= kill_tag(r_stage[i-1], i_kill);
    end
  end

  assign o_head = r_stage[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: memory stage has priority, fetch wins after STARVE_MAX denials;
// read responses are routed back to their owner through lat_tag_pipe.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              fetch_stall
);

  localparam int              SC_W   = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  logic [SC_W-1:0] r_starve_cnt;
  logic            w_if_gnt;
  logic            w_mem_gnt;
  tag_e            w_tag_in;
  tag_e            w_head;

  // Grants are forced low while reset is held so every output reads 0 during reset.
  always_comb begin
    w_if_gnt  = reset && if_req && (!mem_req || (r_starve_cnt == SC_MAX));
    w_mem_gnt = reset && mem_req && !w_if_gnt;
    w_tag_in  = TAG_NONE;
    if (w_if_gnt)                 w_tag_in = TAG_IF;
    else if (w_mem_gnt && !mem_we) w_tag_in = TAG_MEM;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (if_req && !w_if_gnt) begin
      if (r_starve_cnt != SC_MAX) r_starve_cnt <= r_starve_cnt + 1'b1;
    end else begin
      r_starve_cnt <= '0;
    end
  end

  lat_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .reset  (reset),
    .i_tag  (w_tag_in),
    .i_kill (if_kill),
    .o_head (w_head)
  );

  always_comb begin
    if_gnt      = w_if_gnt;
    mem_gnt     = w_mem_gnt;
    fetch_stall = reset && if_req && !w_if_gnt;
    ram_en      = w_if_gnt || w_mem_gnt;
    ram_we      = w_mem_gnt && mem_we;
    ram_addr    = '0;
    ram_wdata   = '0;
    if (w_if_gnt) begin
      ram_addr  = if_addr;
    end else if (w_mem_gnt) begin
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
    end
    if_rvalid   = reset && (w_head == TAG_IF);
    mem_rvalid  = reset && (w_head == TAG_MEM);
    if_rdata    = reset ? ram_rdata : '0;
    mem_rdata   = reset ? ram_rdata : '0;
  end

endmodule
